jt12_wrdec: RTL and testbench
=============================

# jt12_wrdec

CPU write decoder for the JT12 FM core, placed directly upstream of the channel/operator register file. Latches register addresses from the two-part YM2612-style bus, turns data writes into the per-register update strobes plus `din`/`ch`/`op`, and holds each strobe until the register file has swept all 24 slots and dropped its busy. Global registers (0x21–0x2F except 0x28) go out on a one-cycle write port for the timer/LFO/DAC blocks.

## Interface
- No parameters; slot count (24) and handshake timeout (4) are package constants.
- `clk` in 1: core clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_din` in 8: bus data.
- `cpu_addr` in 2: bit0 = 0 address / 1 data; bit1 = part (0 = ch 0–2, 1 = ch 3–5).
- `cpu_cs_n`, `cpu_wr_n` in 1 each: a write is any cycle with both low; only the first cycle of a low run counts.
- `busy_in` in 1: busy from the register file (op or key-on).
- `din` out 8: latched data for the register file.
- `ch` out 3: target channel, 0–5.
- `op` out 2: operator slot, `reg[3:2]`.
- `up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg` out 1 each: level update strobes, one-hot or all zero.
- `glob_we` out 1: one-cycle pulse for a global write.
- `glob_addr`, `glob_data` out 8 each: global register address and data, valid while `glob_we` is high.
- `busy_out` out 1: status bit 7 to the CPU.
- `lost` out 1: sticky; set when a data write is dropped; cleared by reset or by an address write of 0x2F.

## Operation
- **Address write** (`cpu_addr[0]=0`): latch `areg <= cpu_din` and `apart <= cpu_addr[1]`. Accepted in every state.
- **Data write** (`cpu_addr[0]=1`), decode of `areg`:
  - 0x28 → `up_keyon`; `ch` = `din[2:0]`, passed through as written.
  - 0x21–0x2F except 0x28 → `glob_we` pulse. Part 1 globals are ignored and do not set `lost`.
  - 0x30–0x9F with `areg[1:0] != 3`, by high nibble: 3 → `up_dt1`, 4 → `tl`, 5 → `ks_ar`, 6 → `amen_d1r`, 7 → `d2r`, 8 → `d1l`, 9 → `ssgeg`.
  - 0xA0–0xA2 → `fnumlo`; 0xA4–0xA6 → `block`; 0xB0–0xB2 → `alg`; 0xB4–0xB6 → `pms`.
  - Anything else (including 0xA8–0xAE and `areg[1:0]=3`): no strobe, not lost.
  - `ch = apart ? areg[1:0]+3 : areg[1:0]`; `op = areg[3:2]`.
- **FSM**:
  - IDLE: a strobed data write loads `din`/`ch`/`op`, raises the strobe, goes to ARM.
  - ARM: strobe held. `busy_in` = 1 → WAIT. Four cycles without it → timeout, drop the strobe, IDLE.
  - WAIT: strobe held. `busy_in` = 0 → drop the strobe, IDLE.
- **Drops**: a data write in ARM/WAIT, or in IDLE while `busy_in` = 1, is discarded and sets `lost`. `din`/`ch`/`op` stay unchanged.
- Global writes are accepted in any state; they never touch the FSM or the strobes.
- `busy_out = (state != IDLE) | busy_in`.

## Timing
- Reset: state IDLE, `areg` = 0, `apart` = 0, all strobes 0, `glob_we` 0, `din`/`ch`/`op`/`glob_*` 0, `lost` 0. `busy_out` then follows `busy_in` only.
- Data write sampled at edge N → strobe and `din`/`ch`/`op` registered, valid from N+1.
- Register file raises busy at N+2 → WAIT at N+2.
- Strobe falls on the edge after `busy_in` is seen low; a normal update holds about 26 cycles.
- `din`/`ch`/`op` are stable for the whole time the strobe is high.
- Global write at N → `glob_we` high for cycle N+1 only.
- An address write and a data write cannot occur in the same cycle (single `cpu_addr[0]`).
- A data write in the same cycle the FSM returns to IDLE is dropped; the decision uses the pre-edge state.
- Reset asserted mid-update clears strobes and `busy_out` asynchronously.

## Structure
- Package `jt12_pkg`: address constants (`ADDR_KEYON`=0x28, group bases 0x30…0xB4), `SLOTS`=24, `ARM_TIMEOUT`=4, and FSM state enum {IDLE, ARM, WAIT}.
- One sub-module `jt12_wrdec_map`: combinational `areg`/`apart` → one-hot strobe select, `ch`, `op`, `is_global`.

## Test plan
- Write address 0x40 to part 0, then data 0x7F; model `busy_in` high at N+2 and low at N+26 → `up_tl` = 1 from N+1 through N+26, `din` = 0x7F, `ch` = 0, `op` = 0.
- Part 1, address 0xA5, data 0x22 → `up_block`, `ch` = 4, `din` = 0x22, `busy_out` high throughout.
- Address 0x28, data 0xF5 → `up_keyon`, `din` = 0xF5; held until `busy_in` falls.
- Address 0x24, data 0x80 → `glob_we` for exactly one cycle with `glob_addr` = 0x24 and `glob_data` = 0x80; no update strobe.
- A second data write at N+5 during an update → ignored, `lost` = 1. An address write of 0x2F then clears `lost` to 0.
- `busy_in` held at 0 after a write → strobe drops after 4 cycles in ARM. `rst_n` pulsed low in WAIT → all outputs return to their reset values at once.

Source files
------------

// File: rtl/jt12_pkg.sv
// Shared constants and types for the JT12 CPU write decoder.
package jt12_pkg;

  localparam int SLOTS       = 24;  // register file sweep length
  localparam int ARM_TIMEOUT = 4;   // cycles to wait for busy before giving up

  localparam logic [7:0] ADDR_GLOB_LO  = 8'h21;
  localparam logic [7:0] ADDR_KEYON    = 8'h28;
  localparam logic [7:0] ADDR_GLOB_HI  = 8'h2F;
  localparam logic [7:0] ADDR_LOST_CLR = 8'h2F;
  localparam logic [7:0] ADDR_DT1      = 8'h30;
  localparam logic [7:0] ADDR_TL       = 8'h40;
  localparam logic [7:0] ADDR_KS_AR    = 8'h50;
  localparam logic [7:0] ADDR_AMEN_D1R = 8'h60;
  localparam logic [7:0] ADDR_D2R      = 8'h70;
  localparam logic [7:0] ADDR_D1L      = 8'h80;
  localparam logic [7:0] ADDR_SSGEG    = 8'h90;
  localparam logic [7:0] ADDR_FNUMLO   = 8'hA0;
  localparam logic [7:0] ADDR_BLOCK    = 8'hA4;
  localparam logic [7:0] ADDR_ALG      = 8'hB0;
  localparam logic [7:0] ADDR_PMS      = 8'hB4;

  typedef enum logic [1:0] {IDLE, ARM, WAIT} state_t;

  // One-hot update select, MSB first in output port order.
  typedef struct packed {
    logic keyon;
    logic alg;
    logic block;
    logic fnumlo;
    logic pms;
    logic dt1;
    logic tl;
    logic ks_ar;
    logic amen_d1r;
    logic d2r;
    logic d1l;
    logic ssgeg;
  } up_t;

endpackage

// File: rtl/jt12_wrdec_map.sv
// Combinational address map: latched address/part -> update select, ch, op.
module jt12_wrdec_map
  import jt12_pkg::*;
(
  input  logic [7:0] areg,
  input  logic       apart,
  output up_t        sel,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       is_global
);

  // Decode the register group; slot 3 of each group is unused by the chip.
  always_comb begin
    sel       = '0;
    is_global = 1'b0;
    ch        = apart ? ({1'b0, areg[1:0]} + 3'd3) : {1'b0, areg[1:0]};
    op        = areg[3:2];
    if (areg == ADDR_KEYON) begin
      sel.keyon = 1'b1;
    end else if (areg >= ADDR_GLOB_LO && areg <= ADDR_GLOB_HI) begin
      is_global = 1'b1;
    end else if (areg[1:0] != 2'd3) begin
      case (areg[7:4])
        ADDR_DT1[7:4]:      sel.dt1      = 1'b1;
        ADDR_TL[7:4]:       sel.tl       = 1'b1;
        ADDR_KS_AR[7:4]:    sel.ks_ar    = 1'b1;
        ADDR_AMEN_D1R[7:4]: sel.amen_d1r = 1'b1;
        ADDR_D2R[7:4]:      sel.d2r      = 1'b1;
        ADDR_D1L[7:4]:      sel.d1l      = 1'b1;
        ADDR_SSGEG[7:4]:    sel.ssgeg    = 1'b1;
        default: begin
          case ({areg[7:2], 2'b00})
            ADDR_FNUMLO: sel.fnumlo = 1'b1;
            ADDR_BLOCK:  sel.block  = 1'b1;
            ADDR_ALG:    sel.alg    = 1'b1;
            ADDR_PMS:    sel.pms    = 1'b1;
            default:     ;
          endcase
        end
      endcase
    end
  end

endmodule

// File: rtl/jt12_wrdec.sv
// CPU write decoder: address latch, update strobe handshake, global write port.
module jt12_wrdec
  import jt12_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cpu_din,
  input  logic [1:0] cpu_addr,
  input  logic       cpu_cs_n,
  input  logic       cpu_wr_n,
  input  logic       busy_in,
  output logic [7:0] din,
  output logic [2:0] ch,
  output logic [1:0] op,
  output logic       up_keyon,
  output logic       up_alg,
  output logic       up_block,
  output logic       up_fnumlo,
  output logic       up_pms,
  output logic       up_dt1,
  output logic       up_tl,
  output logic       up_ks_ar,
  output logic       up_amen_d1r,
  output logic       up_d2r,
  output logic       up_d1l,
  output logic       up_ssgeg,
  output logic       glob_we,
  output logic [7:0] glob_addr,
  output logic [7:0] glob_data,
  output logic       busy_out,
  output logic       lost
);

  localparam int CW = $clog2(ARM_TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(ARM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    areg;
  logic          apart;
  logic          wr_act_q;
  up_t           up_q;

  up_t           map_sel;
  logic [2:0]    map_ch;
  logic [1:0]    map_op;
  logic          map_glob;

  jt12_wrdec_map u_map (
    .areg      (areg),
    .apart     (apart),
    .sel       (map_sel),
    .ch        (map_ch),
    .op        (map_op),
    .is_global (map_glob)
  );

  // Only the first cycle of a low cs_n/wr_n run is a write.
  logic wr_act, wr, aw, dw, strobe_req, accept, drop, gw, act;
  assign wr_act     = ~cpu_cs_n & ~cpu_wr_n;
  assign wr         = wr_act & ~wr_act_q;
  assign aw         = wr & ~cpu_addr[0];
  assign dw         = wr &  cpu_addr[0];
  assign strobe_req = dw & (|map_sel);
  assign accept     = strobe_req & (state_q == IDLE) & ~busy_in;
  assign drop       = strobe_req & ~accept;
  assign gw         = dw & map_glob & ~apart;
  assign act        = (state_q != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: ARM waits a bounded time for busy, WAIT waits for its release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ARM;
        cnt_d   = '0;
      end
      ARM: begin
        if (busy_in)              state_d = WAIT;
        else if (cnt_q == TO_LAST) state_d = IDLE;
        else                      cnt_d   = cnt_q + 1'b1;
      end
      WAIT: if (!busy_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address latch, update payload, global port and lost flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_act_q  <= 1'b0;
      areg      <= '0;
      apart     <= 1'b0;
      up_q      <= '0;
      din       <= '0;
      ch        <= '0;
      op        <= '0;
      glob_we   <= 1'b0;
      glob_addr <= '0;
      glob_data <= '0;
      lost      <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      glob_we  <= gw;
      if (aw) begin
        areg  <= cpu_din;
        apart <= cpu_addr[1];
      end
      if (accept) begin
        up_q <= map_sel;
        din  <= cpu_din;
        ch   <= map_sel.keyon ? cpu_din[2:0] : map_ch;
        op   <= map_op;
      end
      if (gw) begin
        glob_addr <= areg;
        glob_data <= cpu_din;
      end
      if (drop)                               lost <= 1'b1;
      else if (aw && cpu_din == ADDR_LOST_CLR) lost <= 1'b0;
    end
  end

  // Strobes are only visible while an update is in flight.
  assign up_keyon    = act & up_q.keyon;
  assign up_alg      = act & up_q.alg;
  assign up_block    = act & up_q.block;
  assign up_fnumlo   = act & up_q.fnumlo;
  assign up_pms      = act & up_q.pms;
  assign up_dt1      = act & up_q.dt1;
  assign up_tl       = act & up_q.tl;
  assign up_ks_ar    = act & up_q.ks_ar;
  assign up_amen_d1r = act & up_q.amen_d1r;
  assign up_d2r      = act & up_q.d2r;
  assign up_d1l      = act & up_q.d1l;
  assign up_ssgeg    = act & up_q.ssgeg;
  assign busy_out    = act | busy_in;

endmodule

// File: tb/tb_jt12_wrdec.sv
// Directed bench for jt12_wrdec.
module tb_jt12_wrdec;
  import jt12_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cpu_din;
  logic [1:0] cpu_addr;
  logic       cpu_cs_n, cpu_wr_n, busy_in;
  logic [7:0] din, glob_addr, glob_data;
  logic [2:0] ch;
  logic [1:0] op;
  logic up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1, up_tl;
  logic up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg;
  logic glob_we, busy_out, lost;
  logic [11:0] ups;

  int checks = 0;
  int failures = 0;

  localparam int HOLD = SLOTS + 2;  // last strobe cycle after the write

  jt12_wrdec dut (
    .clk(clk), .rst_n(rst_n), .cpu_din(cpu_din), .cpu_addr(cpu_addr),
    .cpu_cs_n(cpu_cs_n), .cpu_wr_n(cpu_wr_n), .busy_in(busy_in),
    .din(din), .ch(ch), .op(op),
    .up_keyon(up_keyon), .up_alg(up_alg), .up_block(up_block),
    .up_fnumlo(up_fnumlo), .up_pms(up_pms), .up_dt1(up_dt1), .up_tl(up_tl),
    .up_ks_ar(up_ks_ar), .up_amen_d1r(up_amen_d1r), .up_d2r(up_d2r),
    .up_d1l(up_d1l), .up_ssgeg(up_ssgeg),
    .glob_we(glob_we), .glob_addr(glob_addr), .glob_data(glob_data),
    .busy_out(busy_out), .lost(lost)
  );

  assign ups = {up_keyon, up_alg, up_block, up_fnumlo, up_pms, up_dt1,
                up_tl, up_ks_ar, up_amen_d1r, up_d2r, up_d1l, up_ssgeg};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One idle cycle, then a single-cycle bus write; returns in the cycle after the write edge.
  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
    step();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = a; cpu_din = d;
    step();
    cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  // Register-file model: busy in cycles 2..HOLD-1, strobe expected in 1..HOLD.
  // An extra data write is injected in cycle wr_k (0 = none).
  task automatic run_busy(input string tag, input logic [11:0] exp, input logic [7:0] ed,
                          input logic [2:0] ec, input logic [1:0] eo, input int wr_k);
    for (int k = 1; k <= HOLD + 1; k++) begin
      busy_in = (k >= 2 && k <= HOLD - 1);
      if (k == wr_k) begin
        cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 2'b01; cpu_din = 8'hAA;
      end else begin
        cpu_cs_n = 1'b1; cpu_wr_n = 1'b1;
      end
      @(negedge clk);
      chk(tag, {20'b0, ups}, (k <= HOLD) ? {20'b0, exp} : 32'h0);
      chk({tag, "_busy_out"}, {31'b0, busy_out}, {31'b0, k <= HOLD});
      if (k <= HOLD) begin
        chk({tag, "_din"}, {24'b0, din}, {24'b0, ed});
        chk({tag, "_ch"},  {29'b0, ch},  {29'b0, ec});
        chk({tag, "_op"},  {30'b0, op},  {30'b0, eo});
      end
      step();
    end
    busy_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cpu_din = '0; cpu_addr = '0; cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; busy_in = 1'b0;
    step(); step();
    @(negedge clk);
    chk("rst_ups", {20'b0, ups}, 32'h0);
    chk("rst_busy_out", {31'b0, busy_out}, 32'h0);
    chk("rst_lost", {31'b0, lost}, 32'h0);
    chk("rst_din", {24'b0, din}, 32'h0);
    chk("rst_glob_we", {31'b0, glob_we}, 32'h0);
    busy_in = 1'b1;
    #1 chk("rst_busy_follow", {31'b0, busy_out}, 32'h1);
    busy_in = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // TL write, part 0, channel 0 operator 0
    wr(2'b00, 8'h40);
    wr(2'b01, 8'h7F);
    run_busy("tl", 12'h020, 8'h7F, 3'd0, 2'd0, 0);

    // Block write on part 1 -> channel 4, op 1
    wr(2'b10, 8'hA5);
    wr(2'b11, 8'h22);
    run_busy("block", 12'h200, 8'h22, 3'd4, 2'd1, 0);

    // Key-on with a dropped second write mid-update
    wr(2'b00, 8'h28);
    wr(2'b01, 8'hF5);
    run_busy("keyon", 12'h800, 8'hF5, 3'd5, 2'd2, 5);
    @(negedge clk);
    chk("lost_set", {31'b0, lost}, 32'h1);
    step();
    wr(2'b00, 8'h2F);
    @(negedge clk);
    chk("lost_clr", {31'b0, lost}, 32'h0);
    step();

    // Global write: one-cycle pulse, no strobe
    wr(2'b00, 8'h24);
    wr(2'b01, 8'h80);
    @(negedge clk);
    chk("glob_we", {31'b0, glob_we}, 32'h1);
    chk("glob_addr", {24'b0, glob_addr}, 32'h24);
    chk("glob_data", {24'b0, glob_data}, 32'h80);
    chk("glob_ups", {20'b0, ups}, 32'h0);
    chk("glob_busy_out", {31'b0, busy_out}, 32'h0);
    step();
    @(negedge clk);
    chk("glob_we_fall", {31'b0, glob_we}, 32'h0);
    step();

    // Part 1 global is ignored and not lost
    wr(2'b10, 8'h24);
    wr(2'b11, 8'h55);
    @(negedge clk);
    chk("glob1_we", {31'b0, glob_we}, 32'h0);
    chk("glob1_data", {24'b0, glob_data}, 32'h80);
    chk("glob1_lost", {31'b0, lost}, 32'h0);
    step();

    // Unmapped slot 3: no strobe, not lost, payload untouched
    wr(2'b00, 8'h33);
    wr(2'b01, 8'h44);
    @(negedge clk);
    chk("slot3_ups", {20'b0, ups}, 32'h0);
    chk("slot3_busy_out", {31'b0, busy_out}, 32'h0);
    chk("slot3_lost", {31'b0, lost}, 32'h0);
    chk("slot3_din", {24'b0, din}, 32'hF5);
    step();

    // ARM timeout with a long write strobe: only its first cycle counts
    wr(2'b00, 8'h60);
    step();
    cpu_cs_n = 1'b0; cpu_wr_n = 1'b0; cpu_addr = 2'b01; cpu_din = 8'h11;
    for (int k = 1; k <= ARM_TIMEOUT + 1; k++) begin
      step();
      if (k == 3) begin cpu_cs_n = 1'b1; cpu_wr_n = 1'b1; end
      @(negedge clk);
      chk("timeout_ups", {20'b0, ups}, (k <= ARM_TIMEOUT) ? 32'h008 : 32'h0);
    end
    chk("timeout_lost", {31'b0, lost}, 32'h0);
    chk("timeout_din", {24'b0, din}, 32'h11);
    step();

    // Data write in IDLE while busy is high is dropped
    busy_in = 1'b1;
    wr(2'b00, 8'h50);
    wr(2'b01, 8'h9C);
    @(negedge clk);
    chk("idlebusy_ups", {20'b0, ups}, 32'h0);
    chk("idlebusy_lost", {31'b0, lost}, 32'h1);
    chk("idlebusy_din", {24'b0, din}, 32'h11);
    busy_in = 1'b0;
    step();

    // Asynchronous reset while in WAIT
    wr(2'b00, 8'h70);
    wr(2'b01, 8'h33);
    step();
    busy_in = 1'b1;
    step(); step();
    @(negedge clk);
    chk("wait_d2r", {20'b0, ups}, 32'h004);
    #2;
    rst_n = 1'b0;
    busy_in = 1'b0;
    #1;
    chk("arst_ups", {20'b0, ups}, 32'h0);
    chk("arst_busy_out", {31'b0, busy_out}, 32'h0);
    chk("arst_din", {24'b0, din}, 32'h0);
    chk("arst_ch", {29'b0, ch}, 32'h0);
    chk("arst_op", {30'b0, op}, 32'h0);
    chk("arst_lost", {31'b0, lost}, 32'h0);
    chk("arst_glob_addr", {24'b0, glob_addr}, 32'h0);
    chk("arst_glob_data", {24'b0, glob_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
